// File: rtl/lvds_pattern_gen_pkg.sv
// Shared definitions for the LVDS test-pattern generator: FSM states, default
// training/seed words and the PRBS7 (x^7+x^6+1) tap set.
package lvds_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [6:0] TRAIN_WORD_DEF = 7'h70;
  localparam logic [6:0] PRBS_SEED_DEF  = 7'h7F;

  // Feedback taps on bits 6 and 5; one serial step shifts left and appends the XOR.
  localparam logic [6:0] PRBS7_TAPS  = 7'h60;
  localparam int         PRBS7_STEPS = 7;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/lvds_pattern_gen_prbs7_word.sv
// Combinational PRBS7 word advance: applies seven serial LFSR steps so one
// 7-bit word is consumed per parallel clock. Shared with the receive-side checker.
module prbs7_word
  import lvds_pattern_gen_pkg::*;
(
  input  logic [6:0] I_state,
  output logic [6:0] O_next
);

  // Unrolled serial steps.
  always_comb begin
    O_next = I_state;
    for (int i = 0; i < PRBS7_STEPS; i++) begin
      O_next = prbs7_step(O_next);
    end
  end

endmodule

// File: rtl/lvds_pattern_gen.sv
// Transmit-side LVDS test-pattern source: training word, then PRBS7 on P and N.
// Define LVDS_ERR_INJECT_EN to add the I_inject port and the N-channel error injector.
module lvds_pattern_gen
  import lvds_pattern_gen_pkg::*;
#(
  parameter int         TRAIN_CYCLES = 1024,
  parameter logic [6:0] TRAIN_WORD   = TRAIN_WORD_DEF,
  parameter logic [6:0] PRBS_SEED    = PRBS_SEED_DEF
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_en,
  input  logic        I_dpa_done,
  input  logic        I_retrain,
`ifdef LVDS_ERR_INJECT_EN
  input  logic        I_inject,
`endif
  output logic [6:0]  O_pdata,
  output logic [6:0]  O_ndata,
  output logic        O_train,
  output logic        O_run,
  output logic [15:0] O_word_cnt
);

  localparam int                CNT_W   = (TRAIN_CYCLES > 2) ? $clog2(TRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        lfsr_q, lfsr_d, lfsr_adv;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [6:0]        pdata_q, pdata_d;
  logic [6:0]        ndata_q, ndata_d;
  logic              train_q, train_d;
  logic              run_q, run_d;
  logic              enter_train;
  logic [6:0]        inj_mask;

  prbs7_word u_prbs7_word (
    .I_state (lfsr_q),
    .O_next  (lfsr_adv)
  );

  // Next state with priority: disable > retrain > normal transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    wcnt_d      = wcnt_q;
    enter_train = 1'b0;
    if (!I_en) begin
      state_d = ST_IDLE;
    end else if (I_retrain && (state_q != ST_IDLE)) begin
      enter_train = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:  enter_train = 1'b1;
        ST_TRAIN: begin
          if ((cnt_q == CNT_MAX) && I_dpa_done) begin
            state_d = ST_RUN;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end

    if (enter_train) begin
      state_d = ST_TRAIN;
      cnt_d   = '0;
      lfsr_d  = PRBS_SEED;
      wcnt_d  = 16'd0;
    end else if (state_d == ST_RUN) begin
      // lfsr_q is the word being emitted; it advances as it goes out.
      lfsr_d = lfsr_adv;
      wcnt_d = wcnt_q + 16'd1;
    end else if (state_d == ST_IDLE) begin
      wcnt_d = 16'd0;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Injection only counts when the pulse is sampled in RUN and RUN continues.
  always_comb begin
    inj_mask = 7'h00;
`ifdef LVDS_ERR_INJECT_EN
    if (I_inject && (state_q == ST_RUN) && (state_d == ST_RUN)) begin
      inj_mask = 7'h01;
    end else begin
      inj_mask = 7'h00;
    end
`endif
  end

  // Output words and flags follow the next state so they line up with it.
  always_comb begin
    pdata_d = 7'h00;
    ndata_d = 7'h00;
    train_d = 1'b0;
    run_d   = 1'b0;
    case (state_d)
      ST_TRAIN: begin
        pdata_d = TRAIN_WORD;
        ndata_d = TRAIN_WORD;
        train_d = 1'b1;
      end
      ST_RUN: begin
        pdata_d = lfsr_q;
        ndata_d = lfsr_q ^ inj_mask;
        run_d   = 1'b1;
      end
      default: begin
        pdata_d = 7'h00;
        ndata_d = 7'h00;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= PRBS_SEED;
      wcnt_q  <= 16'd0;
      pdata_q <= 7'h00;
      ndata_q <= 7'h00;
      train_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      wcnt_q  <= wcnt_d;
      pdata_q <= pdata_d;
      ndata_q <= ndata_d;
      train_q <= train_d;
      run_q   <= run_d;
    end
  end

  assign O_pdata    = pdata_q;
  assign O_ndata    = ndata_q;
  assign O_train    = train_q;
  assign O_run      = run_q;
  assign O_word_cnt = wcnt_q;

endmodule
